// File: rtl/irq_pkg.sv
// Shared constants for the int_ctrl_up interrupt controller: FSM encodings,
// default vector layout, mask reset value and the vector arithmetic helper.
package irq_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_REQ     = 2'd1;
   localparam logic [1:0] ST_SERVICE = 2'd2;

   localparam logic [7:0] VEC_BASE_DEF   = 8'hE0;
   localparam logic [7:0] VEC_STRIDE_DEF = 8'h04;

   // Wide enough for the largest NUM_IRQ; the top slices what it needs.
   localparam logic [7:0] MASK_RST = 8'hFF;

   function automatic logic [7:0] vec_calc(input logic [7:0] base,
                                           input logic [7:0] stride,
                                           input logic [7:0] id);
      return base + id * stride;
   endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: lowest set request index wins.
module irq_prio_enc #(
   parameter int NUM_IRQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_IRQ-1:0] req,
   output logic               any,
   output logic [ID_W-1:0]    idx
);

   always_comb begin
      any = |req;
      idx = '0;
      for (int unsigned i = NUM_IRQ; i > 0; i--) begin
         if (req[i-1]) idx = ID_W'(i - 1);
      end
   end

endmodule

// File: rtl/int_ctrl_up.sv
// Interrupt controller feeding the intp jump condition of the microcoded control unit.
// Define IRQ_SYNC_EN to insert a 2-flop synchronizer ahead of the IRQ edge detect.
module int_ctrl_up
   import irq_pkg::*;
#(
   parameter int         NUM_IRQ    = 4,
   parameter int         ID_W       = 2,
   parameter logic [7:0] VEC_BASE   = VEC_BASE_DEF,
   parameter logic [7:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               mask_we,
   input  logic [NUM_IRQ-1:0] mask_wdata,
   input  logic               gie,
   input  logic               int_ack,
   input  logic               int_done,
   output logic               intp,
   output logic [7:0]         int_vector,
   output logic [ID_W-1:0]    int_id,
   output logic               in_service,
   output logic [NUM_IRQ-1:0] pending
);

   logic [1:0]         state;
   logic [NUM_IRQ-1:0] mask;
   logic [NUM_IRQ-1:0] irq_s;
   logic [NUM_IRQ-1:0] irq_q;
   logic [NUM_IRQ-1:0] irq_rise;
   logic [NUM_IRQ-1:0] req;
   logic [NUM_IRQ-1:0] ack_clr;
   logic               req_any;
   logic [ID_W-1:0]    prio;
   logic               ack_take;

`ifdef IRQ_SYNC_EN
   logic [NUM_IRQ-1:0] sync1;
   logic [NUM_IRQ-1:0] sync2;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= irq_in;
         sync2 <= sync1;
      end
   end

   always_comb irq_s = sync2;
`else
   always_comb irq_s = irq_in;
`endif

   always_comb begin
      irq_rise = irq_s & ~irq_q;
      req      = pending & ~mask;
      ack_take = (state == ST_REQ) && int_ack;
      ack_clr  = '0;
      if (ack_take) ack_clr[int_id] = 1'b1;
   end

   irq_prio_enc #(
      .NUM_IRQ (NUM_IRQ),
      .ID_W    (ID_W)
   ) u_prio (
      .req (req),
      .any (req_any),
      .idx (prio)
   );

   // A fresh edge on the acknowledged source re-sets its bit (set wins over clear).
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_q   <= '0;
         pending <= '0;
         mask    <= MASK_RST[NUM_IRQ-1:0];
      end else begin
         irq_q   <= irq_s;
         pending <= (pending & ~ack_clr) | irq_rise;
         if (mask_we) mask <= mask_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         intp       <= 1'b0;
         int_id     <= '0;
         int_vector <= VEC_BASE;
         in_service <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (gie && req_any) begin
                  int_id     <= prio;
                  int_vector <= vec_calc(VEC_BASE, VEC_STRIDE, 8'(prio));
                  intp       <= 1'b1;
                  state      <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (int_ack) begin
                  intp       <= 1'b0;
                  in_service <= 1'b1;
                  state      <= ST_SERVICE;
               end
            end
            ST_SERVICE: begin
               if (int_done) begin
                  in_service <= 1'b0;
                  state      <= ST_IDLE;
               end
            end
            default: begin
               intp       <= 1'b0;
               in_service <= 1'b0;
               state      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_int_ctrl_up.sv
// Directed bench for int_ctrl_up: grants are predicted into a scoreboard when IRQs are
// driven and popped when intp rises. Latency expectations follow IRQ_SYNC_EN.
module tb_int_ctrl_up;

`ifdef IRQ_SYNC_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 2;
`endif

   typedef struct {
      int         id;
      logic [7:0] vec;
   } grant_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] irq_in;
   logic       mask_we;
   logic [3:0] mask_wdata;
   logic       gie;
   logic       int_ack;
   logic       int_done;
   logic       intp;
   logic [7:0] int_vector;
   logic [1:0] int_id;
   logic       in_service;
   logic [3:0] pending;

   int checks = 0;
   int errors = 0;
   grant_t sb[$];

   int_ctrl_up #(
      .NUM_IRQ    (4),
      .ID_W       (2),
      .VEC_BASE   (8'hE0),
      .VEC_STRIDE (8'h04)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .irq_in     (irq_in),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .gie        (gie),
      .int_ack    (int_ack),
      .int_done   (int_done),
      .intp       (intp),
      .int_vector (int_vector),
      .int_id     (int_id),
      .in_service (in_service),
      .pending    (pending)
   );

   always #5 clk = ~clk;

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_vec(input int id);
      return 8'(224 + 4 * id);
   endfunction

   task automatic push_grant(input int id);
      grant_t g;
      g.id  = id;
      g.vec = exp_vec(id);
      sb.push_back(g);
   endtask

   task automatic wait_grant(input string tag, input int exp_lat);
      int     cycles;
      grant_t g;
      cycles = 0;
      while (intp !== 1'b1 && cycles < 20) begin
         step();
         cycles++;
      end
      chk({tag, "_intp"}, 32'(intp), 32'd1);
      chk({tag, "_lat"}, 32'(cycles), 32'(exp_lat));
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         g = sb.pop_front();
         chk({tag, "_id"}, 32'(int_id), 32'(g.id));
         chk({tag, "_vec"}, 32'(int_vector), 32'(g.vec));
      end
   endtask

   task automatic pulse_ack();
      int_ack = 1'b1;
      step();
      int_ack = 1'b0;
   endtask

   task automatic pulse_done();
      int_done = 1'b1;
      step();
      int_done = 1'b0;
   endtask

   task automatic write_mask(input logic [3:0] m);
      mask_we    = 1'b1;
      mask_wdata = m;
      step();
      mask_we    = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_intp"}, 32'(intp), 32'd0);
      chk({tag, "_vec"}, 32'(int_vector), 32'hE0);
      chk({tag, "_id"}, 32'(int_id), 32'd0);
      chk({tag, "_insvc"}, 32'(in_service), 32'd0);
      chk({tag, "_pend"}, 32'(pending), 32'd0);
   endtask

   initial begin
      rst = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0;
      gie = 1'b0; int_ack = 1'b0; int_done = 1'b0;
      step(2);
      rst = 1'b0;
      check_reset("reset");

      // Mask is all ones out of reset: an edge sets pending but requests nothing.
      gie = 1'b1;
      irq_in = 4'b0100;
      step(LAT + 2);
      chk("rst_mask_intp", 32'(intp), 32'd0);
      chk("rst_mask_pend", 32'(pending), 32'h4);
      rst = 1'b1; irq_in = '0;
      step();
      rst = 1'b0;

      // 1: single source, basic latency and vector
      write_mask(4'b0000);
      irq_in = 4'b0100;
      push_grant(2);
      wait_grant("t1", LAT);
      pulse_ack();
      chk("t1_ack_intp", 32'(intp), 32'd0);
      chk("t1_ack_insvc", 32'(in_service), 32'd1);
      chk("t1_ack_pend", 32'(pending), 32'd0);
      pulse_done();
      chk("t1_done_insvc", 32'(in_service), 32'd0);
      irq_in = '0;
      step(3);

      // 2: simultaneous sources, priority order; both pulses together take only ack
      irq_in = 4'b1010;
      push_grant(1);
      push_grant(3);
      wait_grant("t2a", LAT);
      pulse_ack();
      pulse_done();
      chk("t2_gap_intp", 32'(intp), 32'd0);
      wait_grant("t2b", 1);
      int_ack = 1'b1; int_done = 1'b1;
      step();
      int_ack = 1'b0; int_done = 1'b0;
      chk("t2_both_insvc", 32'(in_service), 32'd1);
      chk("t2_both_intp", 32'(intp), 32'd0);
      step();
      chk("t2_hold_insvc", 32'(in_service), 32'd1);
      pulse_done();
      chk("t2_done_insvc", 32'(in_service), 32'd0);
      irq_in = '0;
      step(3);

      // 3: masked pending bit held, raised once unmasked
      write_mask(4'b0001);
      irq_in = 4'b0001;
      step(LAT + 2);
      chk("t3_masked_intp", 32'(intp), 32'd0);
      chk("t3_masked_pend", 32'(pending), 32'h1);
      write_mask(4'b0000);
      chk("t3_wr_intp", 32'(intp), 32'd0);
      push_grant(0);
      wait_grant("t3", 1);
      pulse_ack();
      pulse_done();
      irq_in = '0;
      step(3);

      // 4: new edge on the granted source coincides with ack
      irq_in = 4'b0100;
      push_grant(2);
      wait_grant("t4a", LAT);
      irq_in = '0;
      step(3);
      irq_in = 4'b0100;
      if (LAT > 2) step(LAT - 2);
      pulse_ack();
      chk("t4_setwins_pend", 32'(pending), 32'h4);
      chk("t4_insvc", 32'(in_service), 32'd1);
      push_grant(2);
      pulse_done();
      chk("t4_gap_intp", 32'(intp), 32'd0);
      wait_grant("t4b", 1);
      pulse_ack();
      pulse_done();
      irq_in = '0;
      step(3);

      // 5: gie gating, stray pulses in IDLE, reset from SERVICE
      gie = 1'b0;
      irq_in = 4'b0010;
      step(LAT + 2);
      chk("t5_gie_intp", 32'(intp), 32'd0);
      chk("t5_gie_pend", 32'(pending), 32'h2);
      pulse_done();
      chk("t5_done_intp", 32'(intp), 32'd0);
      chk("t5_done_insvc", 32'(in_service), 32'd0);
      pulse_ack();
      chk("t5_ack_pend", 32'(pending), 32'h2);
      gie = 1'b1;
      push_grant(1);
      wait_grant("t5", 1);
      pulse_ack();
      chk("t5_svc_insvc", 32'(in_service), 32'd1);
      rst = 1'b1; irq_in = '0;
      step();
      rst = 1'b0;
      check_reset("t5_rst");
      step(3);
      chk("t5_post_intp", 32'(intp), 32'd0);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
